fetch_sequencer: RTL and testbench

//  Sequences the fetch stage: owns PC write-enable, PC source select and IF/ID, ID/EX bubble control.

---
 rtl/fetch_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage sequencer: PC enable/select, IF/ID and ID/EX bubbles, imem waits
module fetch_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [31:0]      redirect_addr,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             imem_err,
  output logic [CNT_W-1:0] stall_count
);

  // wait_cnt never exceeds TIMEOUT, so it only needs enough bits to hold TIMEOUT itself
  localparam int   WC_W             = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // with TIMEOUT of 1 the very first not-ready cycle already exhausts the budget
  localparam logic FIRST_MISS_HALTS = (TIMEOUT <= 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [31:0]     pend_addr, pend_addr_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            err_nxt;

  logic            hazard;
  logic            redirect_req;
  logic [31:0]     redirect_tgt;
  logic            pend_take_valid;
  logic [31:0]     pend_take_addr;
  logic [WC_W:0]   wait_inc;
  logic            wait_hit;

  // load-use: the load in ID/EX writes a register the IF/ID instruction reads ($0 never hazards)
  assign hazard = ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  // a branch resolving in EX is older than a jump in ID, so it wins and squashes the jump
  assign redirect_req = branch_taken | jump;
  assign redirect_tgt = branch_taken ? branch_target : jump_target;

  // pending redirect as it stands this cycle in WAIT: a branch overrides, a jump only fills an empty slot
  assign pend_take_valid = pend_valid | branch_taken | jump;
  assign pend_take_addr  = branch_taken ? branch_target :
                           (jump & ~pend_valid) ? jump_target : pend_addr;

  assign wait_inc = {1'b0, wait_cnt} + (WC_W + 1)'(1);
  assign wait_hit = (wait_inc >= (WC_W + 1)'(TIMEOUT));

  // state register and the redirect / wait bookkeeping it carries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
      wait_cnt   <= '0;
      imem_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      pend_addr  <= pend_addr_nxt;
      wait_cnt   <= wait_cnt_nxt;
      imem_err   <= err_nxt;
    end
  end

  // next-state: redirects and memory waits pre-empt the load-use stall, LU lasts a single cycle
  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_addr_nxt  = pend_addr;
    wait_cnt_nxt   = wait_cnt;
    err_nxt        = imem_err;
    case (state)
      ST_RUN, ST_LU: begin
        if (!imem_ready) begin
          wait_cnt_nxt = WC_W'(1);
          if (redirect_req) begin
            pend_valid_nxt = 1'b1;
            pend_addr_nxt  = redirect_tgt;
          end
          if (FIRST_MISS_HALTS) begin
            state_nxt = ST_HALT;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else if (!redirect_req && hazard && (state == ST_RUN)) begin
          state_nxt = ST_LU;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (imem_ready) begin
          pend_valid_nxt = 1'b0;
          wait_cnt_nxt   = '0;
          state_nxt      = ST_RUN;
        end else begin
          pend_valid_nxt = pend_take_valid;
          pend_addr_nxt  = pend_take_addr;
          wait_cnt_nxt   = wait_inc[WC_W-1:0];
          if (wait_hit) begin
            state_nxt = ST_HALT;
            err_nxt   = 1'b1;
          end
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  // outputs: decoded from state plus this cycle's inputs, all held low while reset is asserted
  always_comb begin
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    redirect_addr = 32'd0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    if (reset) begin
      case (state)
        ST_RUN, ST_LU: begin
          if (branch_taken) begin
            pc_write      = 1'b1;
            pc_sel        = 1'b1;
            redirect_addr = branch_target;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
          end else if (jump) begin
            pc_write      = 1'b1;
            pc_sel        = 1'b1;
            redirect_addr = jump_target;
            ifid_flush    = 1'b1;
          end else if (!imem_ready) begin
            pc_write = 1'b0;
          end else if (hazard && (state == ST_RUN)) begin
            idex_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        ST_WAIT: begin
          ifid_flush = pend_valid;
          idex_flush = branch_taken;
          if (imem_ready) begin
            pc_write = 1'b1;
            if (pend_take_valid) begin
              pc_sel        = 1'b1;
              redirect_addr = pend_take_addr;
              ifid_flush    = 1'b1;
            end else begin
              ifid_write = 1'b1;
            end
          end
        end
        default: pc_write = 1'b0;
      endcase
    end
  end

  // stall counter: counts cycles the PC is held, saturating, frozen once halted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if ((state != ST_HALT) && !pc_write && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed bench for fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

  localparam int TO        = 16;
  localparam int STALL_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target;

  logic        pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, imem_err;
  logic [31:0] redirect_addr;
  logic [15:0] stall_count;

  logic        pc_write2, pc_sel2, ifid_write2, ifid_flush2, idex_flush2, imem_err2;
  logic [31:0] redirect_addr2;
  logic [3:0]  stall_count2;

  int errors = 0;
  int checks = 0;

  // model state: what the fetch stage is doing, not how the RTL encodes it
  bit          m_halted, m_waiting, m_after_lu, m_pv, m_err;
  logic [31:0] m_pa;
  int          m_miss, m_stalls;
  bit          e_pw, e_sel, e_iw, e_if, e_xf, e_hz;
  logic [31:0] e_redir;
  logic [4:0]  ctl, e_ctl;

  assign ctl = {pc_write, pc_sel, ifid_write, ifid_flush, idex_flush};

  fetch_sequencer #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_ready(imem_ready), .pc_write(pc_write), .pc_sel(pc_sel), .redirect_addr(redirect_addr),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .imem_err(imem_err),
    .stall_count(stall_count));

  fetch_sequencer #(.TIMEOUT(32), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_ready(imem_ready), .pc_write(pc_write2), .pc_sel(pc_sel2), .redirect_addr(redirect_addr2),
    .ifid_write(ifid_write2), .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .imem_err(imem_err2),
    .stall_count(stall_count2));

  always #5 clk = ~clk;

  task automatic model_clear();
    m_halted = 0; m_waiting = 0; m_after_lu = 0; m_pv = 0; m_err = 0;
    m_pa = 0; m_miss = 0; m_stalls = 0;
  endtask

  task automatic set_idle();
    id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3; ex_mem_read = 0;
    branch_taken = 0; jump = 0; branch_target = 0; jump_target = 0; imem_ready = 1;
  endtask

  task automatic set_random();
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
    ex_mem_read   = ($urandom_range(0, 1) == 1);
    branch_taken  = ($urandom_range(0, 7) == 0);
    jump          = ($urandom_range(0, 7) == 0);
    branch_target = $urandom & 32'hFFFF_FFFC;
    jump_target   = $urandom & 32'hFFFF_FFFC;
    imem_ready    = ($urandom_range(0, 3) != 0);
  endtask

  // expected outputs for the current inputs, from the fetch-stage rules
  task automatic model_eval();
    bit          nv;
    logic [31:0] na;
    if (!reset) model_clear();
    {e_pw, e_sel, e_iw, e_if, e_xf, e_hz} = '0;
    e_redir = 0;
    if (reset && !m_halted) begin
      if (m_waiting) begin
        nv = m_pv; na = m_pa;
        if (branch_taken) begin nv = 1; na = branch_target; e_xf = 1; end
        else if (jump && !m_pv) begin nv = 1; na = jump_target; end
        e_if = m_pv;
        if (imem_ready) begin
          e_pw = 1;
          if (nv) begin e_sel = 1; e_redir = na; e_if = 1; end
          else e_iw = 1;
        end
      end else begin
        e_hz = !m_after_lu && ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
        if (branch_taken) begin e_pw = 1; e_sel = 1; e_redir = branch_target; e_if = 1; e_xf = 1; end
        else if (jump) begin e_pw = 1; e_sel = 1; e_redir = jump_target; e_if = 1; end
        else if (imem_ready && e_hz) e_xf = 1;
        else if (imem_ready) begin e_pw = 1; e_iw = 1; end
      end
    end
    e_ctl = {e_pw, e_sel, e_iw, e_if, e_xf};
  endtask

  // what the coming clock edge does to the model
  task automatic model_commit();
    if (!reset || m_halted) return;
    if (!e_pw && m_stalls < STALL_MAX) m_stalls++;
    if (m_waiting) begin
      if (branch_taken) begin m_pv = 1; m_pa = branch_target; end
      else if (jump && !m_pv) begin m_pv = 1; m_pa = jump_target; end
      if (imem_ready) begin m_waiting = 0; m_pv = 0; m_miss = 0; end
      else begin
        m_miss++;
        if (m_miss >= TO) begin m_halted = 1; m_err = 1; end
      end
      m_after_lu = 0;
    end else begin
      m_after_lu = imem_ready && !branch_taken && !jump && e_hz;
      if (!imem_ready) begin
        if (branch_taken || jump) begin m_pv = 1; m_pa = branch_taken ? branch_target : jump_target; end
        m_waiting = 1; m_miss = 1;
        if (m_miss >= TO) begin m_halted = 1; m_err = 1; end
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0;
    set_idle();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    set_random();
    branch_taken = 1; jump = 1; imem_ready = 0;
    @(posedge clk);
    #2;
    checks++;
    if (ctl !== 5'b0 || redirect_addr !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: got ctl=%b redir=%h, expected ctl=00000 redir=0", ctl, redirect_addr);
    end
    checks++;
    if (stall_count !== 16'd0 || imem_err !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got stall=%0d err=%b, expected 0/0", stall_count, imem_err);
    end
    checks++;
    if ({pc_write2, ifid_write2, pc_sel2} !== 3'b0) begin
      errors++; $display("FAIL reset_dut2: got %b, expected 000", {pc_write2, ifid_write2, pc_sel2});
    end
    @(negedge clk);
    model_clear();
    set_idle();
    reset = 1;
  endtask

  task automatic test_run_stream();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_idle();
      id_rs = 5'($urandom_range(0, 31));
      settle();
      checks++;
      if ({pc_write, ifid_write, pc_sel} !== 3'b110 || ctl !== e_ctl) begin
        errors++; $display("FAIL run_stream c%0d: got ctl=%b, expected ctl=%b", c, ctl, e_ctl);
      end
      advance();
    end
    settle();
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL run_stream_stalls: got %0d, expected 0", stall_count);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_idle();
      ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5;
      settle();
      checks++;
      if (c == 0 && (pc_write !== 1'b0 || idex_flush !== 1'b1 || ifid_write !== 1'b0)) begin
        errors++; $display("FAIL load_use_stall: got pc_write=%b idex_flush=%b, expected 0/1", pc_write, idex_flush);
      end
      if (c == 1 && (pc_write !== 1'b1 || idex_flush !== 1'b0)) begin
        errors++; $display("FAIL load_use_release: got pc_write=%b idex_flush=%b, expected 1/0", pc_write, idex_flush);
      end
      advance();
    end
    set_idle();
    settle();
    checks++;
    if (stall_count !== 16'd1) begin
      errors++; $display("FAIL load_use_count: got %0d, expected 1", stall_count);
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    set_idle();
    branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h99C;
    ex_mem_read = 1; ex_rt = 5'd7; id_rt = 5'd7;
    settle();
    checks++;
    if (pc_sel !== 1'b1 || redirect_addr !== 32'h40 || pc_write !== 1'b1) begin
      errors++; $display("FAIL branch_jump_redirect: got sel=%b addr=%h, expected 1/00000040", pc_sel, redirect_addr);
    end
    checks++;
    if (ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin
      errors++; $display("FAIL branch_jump_flush: got %b%b, expected 11", ifid_flush, idex_flush);
    end
    advance();
  endtask

  task automatic test_wait_redirect();
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      set_idle();
      imem_ready = 0;
      if (c == 2) begin jump = 1; jump_target = 32'h80; end
      settle();
      checks++;
      if (pc_write !== 1'b0 || ctl !== e_ctl) begin
        errors++; $display("FAIL wait_hold c%0d: got ctl=%b, expected ctl=%b", c, ctl, e_ctl);
      end
      advance();
    end
    set_idle();
    settle();
    checks++;
    if (pc_write !== 1'b1 || pc_sel !== 1'b1 || redirect_addr !== 32'h80) begin
      errors++; $display("FAIL wait_release: got pw=%b sel=%b addr=%h, expected 1/1/00000080", pc_write, pc_sel, redirect_addr);
    end
    checks++;
    if (stall_count !== 16'd3) begin
      errors++; $display("FAIL wait_stalls: got %0d, expected 3", stall_count);
    end
    advance();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < TO; c++) begin
      set_idle();
      imem_ready = 0;
      settle();
      checks++;
      if (imem_err !== 1'b0 || pc_write !== 1'b0) begin
        errors++; $display("FAIL timeout_early c%0d: got err=%b pw=%b, expected 0/0", c, imem_err, pc_write);
      end
      advance();
    end
    for (int c = 0; c < 5; c++) begin
      set_random();
      settle();
      checks++;
      if (imem_err !== 1'b1 || ctl !== 5'b0 || stall_count !== 16'(TO)) begin
        errors++; $display("FAIL timeout_halt c%0d: got err=%b ctl=%b stall=%0d, expected 1/00000/%0d", c, imem_err, ctl, stall_count, TO);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_idle();
      imem_ready = 0;
      if (c == 4) begin branch_taken = 1; branch_target = 32'h1230; end
      settle();
      advance();
    end
    set_idle();
    imem_ready = 0;
    settle();
    checks++;
    if (stall_count2 !== 4'd15 || imem_err2 !== 1'b0) begin
      errors++; $display("FAIL stall_saturate: got %0d err=%b, expected 15/0", stall_count2, imem_err2);
    end
    reset = 0;
    #1;
    checks++;
    if (stall_count2 !== 4'd0 || pc_write2 !== 1'b0 || ifid_flush2 !== 1'b0) begin
      errors++; $display("FAIL midwait_reset: got stall=%0d pw=%b, expected 0/0", stall_count2, pc_write2);
    end
    @(negedge clk);
    reset = 1;
    model_clear();
    set_idle();
    #1;
    checks++;
    if ({pc_write2, ifid_write2, pc_sel2, ifid_flush2} !== 4'b1100 || redirect_addr2 !== 32'd0) begin
      errors++; $display("FAIL after_reset_run: got %b addr=%h, expected 1100/0", {pc_write2, ifid_write2, pc_sel2, ifid_flush2}, redirect_addr2);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_random();
      reset = !(m_halted || $urandom_range(0, 79) == 0);
      settle();
      checks++;
      if (ctl !== e_ctl || redirect_addr !== e_redir) begin
        errors++; $display("FAIL random_ctl c%0d: got ctl=%b addr=%h, expected ctl=%b addr=%h", c, ctl, redirect_addr, e_ctl, e_redir);
      end
      checks++;
      if (stall_count !== 16'(m_stalls) || imem_err !== m_err) begin
        errors++; $display("FAIL random_regs c%0d: got stall=%0d err=%b, expected %0d/%b", c, stall_count, imem_err, m_stalls, m_err);
      end
      advance();
    end
    reset = 1;
  endtask

  initial begin
    set_idle();
    model_clear();
    test_reset();
    test_run_stream();
    test_load_use();
    test_branch_jump();
    test_wait_redirect();
    test_timeout();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
